shared_timer_sched: RTL



---
 rtl/shared_timer_pkg.sv | 28 ++
 rtl/shared_timer_sched_rr_arbiter.sv | 37 +++
 rtl/shared_timer_sched.sv | 129 ++++++++++++
 3 files changed

// File: rtl/shared_timer_pkg.sv
// -----------------------------------------------------------------------------
// shared_timer_pkg
// Shared types and constants for the shared countdown timer scheduler.
//   state_e     : scheduler state (IDLE / RUN)
//   NUM_REQ_DEF : default number of requesters
//   WIDTH_DEF   : default counter / duration width
//   MAX_REQ     : widest requester vector onehot() can produce
//   onehot(idx) : one-hot vector with bit idx set (callers truncate to NUM_REQ)
// -----------------------------------------------------------------------------
package shared_timer_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int WIDTH_DEF   = 7;
    localparam int MAX_REQ     = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic logic [MAX_REQ-1:0] onehot(input int idx);
        logic [MAX_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/shared_timer_sched_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick. Searches req from last+1 upward,
// wrapping, and reports the first set bit. The caller owns the pointer.
//   req    : request vector
//   last   : index of the previous winner
//   winner : index of the selected requester (valid only when valid=1)
//   valid  : at least one request bit is set
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [IDX_W-1:0]   winner,
    output logic               valid
);

    int idx;

    // Walk the candidates from farthest to nearest so the nearest set bit
    // after last is the final assignment and therefore the winner.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(last) + k) % NUM_REQ;
            if (req[idx]) begin
                valid  = 1'b1;
                winner = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/shared_timer_sched.sv
// -----------------------------------------------------------------------------
// shared_timer_sched
// Round-robin scheduler sharing one loadable down-counter among NUM_REQ
// requesters. A winner is granted, the counter is loaded with its duration and
// counted to zero, then a one-cycle done pulse goes to the owner.
//   clk, reset : clock, asynchronous active-high reset
//   req        : per-requester level request (dropping it while owner = abort)
//   dur        : packed durations, requester i uses dur[i*WIDTH +: WIDTH]
//   hold       : (only with SHARED_TIMER_HOLD_EN) freeze the count in RUN
//   grant      : registered one-hot owner, high for the whole interval
//   done       : registered one-cycle completion pulse to the owner
//   busy       : high while in RUN
//   count      : current counter value
// Optional feature macro: SHARED_TIMER_HOLD_EN adds the hold input.
// -----------------------------------------------------------------------------
module shared_timer_sched
    import shared_timer_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int WIDTH   = WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] dur,
`ifdef SHARED_TIMER_HOLD_EN
    input  logic                     hold,
`endif
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy,
    output logic [WIDTH-1:0]         count
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   done_q,  done_d;
    logic [WIDTH-1:0]     count_q, count_d;
    logic [IDX_W-1:0]     last_q,  last_d;

    logic [IDX_W-1:0]     arb_winner;
    logic                 arb_valid;
    logic                 hold_active;
    logic [WIDTH-1:0]     dur_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_dur
            assign dur_arr[gi] = dur[gi*WIDTH +: WIDTH];
        end
    endgenerate

`ifdef SHARED_TIMER_HOLD_EN
    assign hold_active = hold;
`else
    assign hold_active = 1'b0;
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req    (req),
        .last   (last_q),
        .winner (arb_winner),
        .valid  (arb_valid)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        done_d  = '0;          // done is a single-cycle pulse
        count_d = count_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    state_d = RUN;
                    grant_d = NUM_REQ'(onehot(int'(arb_winner)));
                    count_d = dur_arr[arb_winner];
                    last_d  = arb_winner;
                end
            end
            RUN: begin
                // Abort wins over completion and hold; count is left as-is.
                if ((req & grant_q) == '0) begin
                    state_d = IDLE;
                    grant_d = '0;
                end else if (!hold_active) begin
                    if (count_q != '0) begin
                        count_d = count_q - 1'b1;
                    end else begin
                        done_d  = grant_q;
                        grant_d = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            done_q  <= '0;
            count_q <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);   // requester 0 gets first priority
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            count_q <= count_d;
            last_q  <= last_d;
        end
    end

    assign grant = grant_q;
    assign done  = done_q;
    assign busy  = (state_q == RUN);
    assign count = count_q;

endmodule
